// File: rtl/if_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package if_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_INCR_DEF  = 32'd4;

    // FETCH: normal operation. DRAIN: waiting out a request orphaned by a redirect.
    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_DRAIN = 1'b1
    } fetch_state_t;

    // One fetched instruction together with the address it came from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] ir;
    } fetch_pair_t;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory read channel: req/addr out of the fetch unit, ack/rdata back.
interface if_fetch_unit_if import if_pkg::*; ();

    logic            imem_req_out;
    logic [XLEN-1:0] imem_addr_out;
    logic            imem_ack_in;
    logic [XLEN-1:0] imem_rdata_in;

    modport master (
        output imem_req_out,
        output imem_addr_out,
        input  imem_ack_in,
        input  imem_rdata_in
    );

    modport slave (
        input  imem_req_out,
        input  imem_addr_out,
        output imem_ack_in,
        output imem_rdata_in
    );

endinterface

// File: rtl/if_skid_buffer.sv
// One-entry {pc, ir} holding register that parks a memory response while ID is stalled.
module if_skid_buffer
    import if_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_wr_en,
    input  logic        i_rd_en,
    input  logic        i_clear,
    input  fetch_pair_t i_data,
    output fetch_pair_t o_data,
    output logic        o_full
);

    fetch_pair_t r_data;
    logic        r_full;

    // Occupancy flag: a flush beats a write, a write beats a read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= 1'b0;
        end else if (i_clear) begin
            r_full <= 1'b0;
        end else if (i_wr_en) begin
            r_full <= 1'b1;
        end else if (i_rd_en) begin
            r_full <= 1'b0;
        end
    end

    // Payload is captured only on a write that is not being flushed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
        end else if (i_wr_en && !i_clear) begin
            r_data <= i_data;
        end
    end

    assign o_data = r_data;
    assign o_full = r_full;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, talks req/ack to instruction memory and
// presents {pc, ir} to ID with valid/stall, parking one response in a skid buffer.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
    parameter logic [XLEN-1:0] PC_INCR  = PC_INCR_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_in,
    input  logic            redirect_in,
    input  logic [XLEN-1:0] redirect_pc_in,
    if_fetch_unit_if.master imem,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] ir_out,
    output logic            valid_out
);

    fetch_state_t    r_state;
    fetch_state_t    w_state_next;
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_req_addr;
    logic            r_req;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_ir;
    logic            r_valid;

    logic            w_ack;
    logic            w_hold_req;
    logic            w_slot_free;
    logic            w_load_mem;
    logic            w_load_skid;
    logic            w_skid_wr;
    logic            w_skid_full;
    logic            w_skid_full_next;
    logic [XLEN-1:0] w_fetch_pc_next;
    fetch_pair_t     w_skid_in;
    fetch_pair_t     w_skid_out;

    assign w_skid_in = {r_fetch_pc, imem.imem_rdata_in};

    if_skid_buffer u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_wr_en (w_skid_wr),
        .i_rd_en (w_load_skid),
        .i_clear (redirect_in),
        .i_data  (w_skid_in),
        .o_data  (w_skid_out),
        .o_full  (w_skid_full)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Redirect with an unanswered request must wait that request out in DRAIN.
    always_comb begin
        w_state_next = r_state;
        if (redirect_in) begin
            w_state_next = (r_req && !imem.imem_ack_in) ? ST_DRAIN : ST_FETCH;
        end else if (r_state == ST_DRAIN && r_req && imem.imem_ack_in) begin
            w_state_next = ST_FETCH;
        end
    end

    // Per-cycle decode: where an ack goes, whether the skid drains, next fetch PC.
    always_comb begin
        w_ack           = r_req && imem.imem_ack_in;
        w_hold_req      = r_req && !imem.imem_ack_in;
        w_slot_free     = !r_valid || !stall_in;
        w_load_mem      = 1'b0;
        w_load_skid     = 1'b0;
        w_skid_wr       = 1'b0;
        w_fetch_pc_next = r_fetch_pc;
        if (redirect_in) begin
            w_fetch_pc_next = redirect_pc_in;
        end else if (r_state == ST_FETCH) begin
            if (w_ack) begin
                w_fetch_pc_next = r_fetch_pc + PC_INCR;
                if (w_slot_free) begin
                    w_load_mem = 1'b1;
                end else begin
                    w_skid_wr = 1'b1;
                end
            end else if (w_skid_full && w_slot_free) begin
                w_load_skid = 1'b1;
            end
        end
        w_skid_full_next = w_skid_wr || (w_skid_full && !w_load_skid && !redirect_in);
    end

    // PC and memory request: an unanswered request is frozen; otherwise request
    // the next fetch PC whenever the skid will be empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_req      <= 1'b0;
            r_req_addr <= RESET_PC;
        end else begin
            r_fetch_pc <= w_fetch_pc_next;
            if (!w_hold_req) begin
                r_req      <= !w_skid_full_next;
                r_req_addr <= w_fetch_pc_next;
            end
        end
    end

    // Output slot toward ID: flush on redirect, else load from memory or skid,
    // else empty once consumed; held while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= '0;
            r_ir    <= '0;
            r_valid <= 1'b0;
        end else if (redirect_in) begin
            r_valid <= 1'b0;
        end else if (w_load_mem) begin
            r_pc    <= r_fetch_pc;
            r_ir    <= imem.imem_rdata_in;
            r_valid <= 1'b1;
        end else if (w_load_skid) begin
            r_pc    <= w_skid_out.pc;
            r_ir    <= w_skid_out.ir;
            r_valid <= 1'b1;
        end else if (!stall_in) begin
            r_valid <= 1'b0;
        end
    end

    assign imem.imem_req_out  = r_req;
    assign imem.imem_addr_out = r_req_addr;
    assign pc_out             = r_pc;
    assign ir_out             = r_ir;
    assign valid_out          = r_valid;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: memory model with programmable wait, transfer monitor
// feeding a scoreboard, and one task per scenario.
module tb_if_fetch_unit;
    import if_pkg::*;

    localparam logic [31:0] PAT = 32'hA5A5_0000;

    logic        clk;
    logic        rst_n;
    logic        stall_in;
    logic        redirect_in;
    logic [31:0] redirect_pc_in;
    logic [31:0] pc_out, ir_out;
    logic        valid_out;
    logic        stall_w;
    logic [31:0] pc_w, ir_w;
    logic        valid_w;
    int          mem_wait;
    int          mem_cnt;
    int          n_checks;
    int          n_fail;
    logic [63:0] got_q[$];
    logic [63:0] exp_q[$];

    if_fetch_unit_if mif ();
    if_fetch_unit_if mif_w ();

    if_fetch_unit u_dut (
        .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .redirect_in(redirect_in),
        .redirect_pc_in(redirect_pc_in), .imem(mif),
        .pc_out(pc_out), .ir_out(ir_out), .valid_out(valid_out)
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .PC_INCR(32'd4)) u_dut_w (
        .clk(clk), .rst_n(rst_n), .stall_in(stall_w), .redirect_in(1'b0),
        .redirect_pc_in(32'h0), .imem(mif_w),
        .pc_out(pc_w), .ir_out(ir_w), .valid_out(valid_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: acks after mem_wait cycles of an unanswered request; data = addr ^ PAT.
    assign mif.imem_ack_in   = mif.imem_req_out && (mem_cnt >= mem_wait);
    assign mif.imem_rdata_in = mif.imem_addr_out ^ PAT;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mem_cnt <= 0;
        else if (mif.imem_req_out && !mif.imem_ack_in) mem_cnt <= mem_cnt + 1;
        else mem_cnt <= 0;
    end

    assign mif_w.imem_ack_in   = mif_w.imem_req_out;
    assign mif_w.imem_rdata_in = mif_w.imem_addr_out ^ PAT;

    // Transfer monitor: record every pair ID accepts.
    always @(posedge clk) begin
        if (rst_n && valid_out && !stall_in) got_q.push_back({pc_out, ir_out});
    end

    task automatic do_reset(input int wait_cycles);
        rst_n = 1'b0; stall_in = 1'b0; redirect_in = 1'b0; redirect_pc_in = '0;
        mem_wait = wait_cycles;
        repeat (2) @(posedge clk);
        #1;
        got_q.delete();
        exp_q.delete();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall_in = 1'b0; redirect_in = 1'b0; redirect_pc_in = '0; mem_wait = 0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (mif.imem_req_out !== 1'b0 || mif.imem_addr_out !== 32'h0 || pc_out !== 32'h0 ||
            ir_out !== 32'h0 || valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: req=%b addr=%h pc=%h ir=%h valid=%b required 0/0/0/0/0",
                     mif.imem_req_out, mif.imem_addr_out, pc_out, ir_out, valid_out);
        end
        n_checks++;
        if (mif_w.imem_addr_out !== 32'hFFFF_FFF8 || mif_w.imem_req_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pc_param: addr=%h req=%b required FFFFFFF8/0",
                     mif_w.imem_addr_out, mif_w.imem_req_out);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (mif.imem_req_out !== 1'b1 || mif.imem_addr_out !== 32'h0 || valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL first_request: req=%b addr=%h valid=%b required 1/00000000/0",
                     mif.imem_req_out, mif.imem_addr_out, valid_out);
        end
    endtask

    task automatic test_zero_wait();
        logic [63:0] got, exp;
        do_reset(0);
        for (int k = 0; k < 4; k++) exp_q.push_back({32'(k * 4), 32'(k * 4) ^ PAT});
        for (int i = 0; i <= 5; i++) begin
            @(posedge clk); #1;
            if (i >= 1 && i <= 4) begin
                n_checks++;
                if (valid_out !== 1'b1 || pc_out !== 32'((i - 1) * 4) ||
                    ir_out !== (32'((i - 1) * 4) ^ PAT)) begin
                    n_fail++;
                    $display("FAIL zero_wait_cycle%0d: valid=%b pc=%h ir=%h required pc=%h",
                             i, valid_out, pc_out, ir_out, 32'((i - 1) * 4));
                end
            end else if (i == 0) begin
                n_checks++;
                if (valid_out !== 1'b0) begin
                    n_fail++;
                    $display("FAIL zero_wait_early_valid: valid=%b required 0", valid_out);
                end
            end
        end
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            n_checks++;
            if (got_q.size() == 0) begin
                n_fail++;
                $display("FAIL zero_wait_sb: no transfer, required %h", exp);
            end else begin
                got = got_q.pop_front();
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL zero_wait_sb: got %h required %h", got, exp);
                end
            end
        end
    endtask

    task automatic test_wait2();
        logic        prev_pend;
        logic [31:0] prev_addr;
        logic        exp_v;
        logic [63:0] got, exp;
        do_reset(2);
        prev_pend = 1'b0;
        prev_addr = '0;
        for (int k = 0; k < 3; k++) exp_q.push_back({32'(k * 4), 32'(k * 4) ^ PAT});
        for (int i = 0; i <= 10; i++) begin
            @(posedge clk); #1;
            if (prev_pend) begin
                n_checks++;
                if (mif.imem_req_out !== 1'b1 || mif.imem_addr_out !== prev_addr) begin
                    n_fail++;
                    $display("FAIL wait2_addr_stable: req=%b addr=%h required 1/%h",
                             mif.imem_req_out, mif.imem_addr_out, prev_addr);
                end
            end
            prev_pend = mif.imem_req_out && !mif.imem_ack_in;
            prev_addr = mif.imem_addr_out;
            exp_v = (i == 3 || i == 6 || i == 9);
            n_checks++;
            if (valid_out !== exp_v || (exp_v && pc_out !== 32'((i / 3 - 1) * 4))) begin
                n_fail++;
                $display("FAIL wait2_cycle%0d: valid=%b pc=%h required valid=%b", i, valid_out,
                         pc_out, exp_v);
            end
        end
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            n_checks++;
            if (got_q.size() == 0) begin
                n_fail++;
                $display("FAIL wait2_sb: no transfer, required %h", exp);
            end else begin
                got = got_q.pop_front();
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL wait2_sb: got %h required %h", got, exp);
                end
            end
        end
    endtask

    task automatic test_stall_skid();
        logic [63:0] got, exp;
        do_reset(0);
        for (int k = 0; k < 4; k++) exp_q.push_back({32'(k * 4), 32'(k * 4) ^ PAT});
        repeat (3) @(posedge clk);
        #1;
        stall_in = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(posedge clk); #1;
            n_checks++;
            if (valid_out !== 1'b1 || pc_out !== 32'h4 || ir_out !== (32'h4 ^ PAT) ||
                mif.imem_req_out !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold%0d: valid=%b pc=%h ir=%h req=%b required 1/4/%h/0",
                         j, valid_out, pc_out, ir_out, mif.imem_req_out, 32'h4 ^ PAT);
            end
        end
        stall_in = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (valid_out !== 1'b1 || pc_out !== 32'h8 || ir_out !== (32'h8 ^ PAT) ||
            mif.imem_req_out !== 1'b1 || mif.imem_addr_out !== 32'hC) begin
            n_fail++;
            $display("FAIL skid_drain: valid=%b pc=%h req=%b addr=%h required 1/8/1/0000000c",
                     valid_out, pc_out, mif.imem_req_out, mif.imem_addr_out);
        end
        repeat (2) @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            n_checks++;
            if (got_q.size() == 0) begin
                n_fail++;
                $display("FAIL stall_sb: no transfer, required %h", exp);
            end else begin
                got = got_q.pop_front();
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL stall_sb: got %h required %h", got, exp);
                end
            end
        end
    endtask

    task automatic test_redirect_outstanding();
        logic        seen_new, seen_valid;
        logic [63:0] got;
        do_reset(2);
        seen_new = 1'b0;
        seen_valid = 1'b0;
        @(posedge clk); #1;
        redirect_in = 1'b1;
        redirect_pc_in = 32'h0000_0100;
        @(posedge clk); #1;
        redirect_in = 1'b0;
        n_checks++;
        if (valid_out !== 1'b0 || mif.imem_req_out !== 1'b1 || mif.imem_addr_out !== 32'h0) begin
            n_fail++;
            $display("FAIL redir_drain: valid=%b req=%b addr=%h required 0/1/00000000",
                     valid_out, mif.imem_req_out, mif.imem_addr_out);
        end
        for (int k = 0; k < 20 && !seen_valid; k++) begin
            @(posedge clk); #1;
            if (!seen_new && mif.imem_req_out && mif.imem_addr_out !== 32'h0) begin
                seen_new = 1'b1;
                n_checks++;
                if (mif.imem_addr_out !== 32'h100) begin
                    n_fail++;
                    $display("FAIL redir_new_addr: addr=%h required 00000100", mif.imem_addr_out);
                end
            end
            if (valid_out) begin
                seen_valid = 1'b1;
                n_checks++;
                if (pc_out !== 32'h100 || ir_out !== (32'h100 ^ PAT)) begin
                    n_fail++;
                    $display("FAIL redir_first_valid: pc=%h ir=%h required 00000100/%h",
                             pc_out, ir_out, 32'h100 ^ PAT);
                end
            end
        end
        if (!seen_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL redir_timeout: no valid output within 20 cycles, required pc 00000100");
        end
        @(posedge clk); #1;
        n_checks++;
        if (got_q.size() == 0) begin
            n_fail++;
            $display("FAIL redir_sb: no transfer, required pc 00000100");
        end else begin
            got = got_q.pop_front();
            if (got !== {32'h100, 32'h100 ^ PAT}) begin
                n_fail++;
                $display("FAIL redir_sb: got %h required %h", got, {32'h100, 32'h100 ^ PAT});
            end
        end
    endtask

    task automatic test_redirect_ack_stall();
        logic [63:0] got, exp;
        do_reset(0);
        for (int k = 0; k < 3; k++) exp_q.push_back({32'h200 + 32'(k * 4), (32'h200 + 32'(k * 4)) ^ PAT});
        repeat (2) @(posedge clk);
        #1;
        stall_in = 1'b1;
        redirect_in = 1'b1;
        redirect_pc_in = 32'h0000_0200;
        @(posedge clk); #1;
        redirect_in = 1'b0;
        n_checks++;
        if (valid_out !== 1'b0 || mif.imem_req_out !== 1'b1 || mif.imem_addr_out !== 32'h200) begin
            n_fail++;
            $display("FAIL redir_ack_flush: valid=%b req=%b addr=%h required 0/1/00000200",
                     valid_out, mif.imem_req_out, mif.imem_addr_out);
        end
        for (int j = 0; j < 2; j++) begin
            @(posedge clk); #1;
            n_checks++;
            if (valid_out !== 1'b1 || pc_out !== 32'h200 || ir_out !== (32'h200 ^ PAT)) begin
                n_fail++;
                $display("FAIL redir_ack_target%0d: valid=%b pc=%h required 1/00000200",
                         j, valid_out, pc_out);
            end
        end
        stall_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            n_checks++;
            if (got_q.size() == 0) begin
                n_fail++;
                $display("FAIL redir_ack_sb: no transfer, required %h", exp);
            end else begin
                got = got_q.pop_front();
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL redir_ack_sb: got %h required %h", got, exp);
                end
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'hFFFF_FFF8;
        exp_pc[1] = 32'hFFFF_FFFC;
        exp_pc[2] = 32'h0000_0000;
        do_reset(0);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (valid_w !== 1'b1 || pc_w !== exp_pc[i] || ir_w !== (exp_pc[i] ^ PAT)) begin
                n_fail++;
                $display("FAIL wrap%0d: valid=%b pc=%h ir=%h required pc=%h", i, valid_w, pc_w,
                         ir_w, exp_pc[i]);
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset(0);
        repeat (3) @(posedge clk);
        #1;
        stall_in = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (mif.imem_req_out !== 1'b0 || mif.imem_addr_out !== 32'h0 || pc_out !== 32'h0 ||
            ir_out !== 32'h0 || valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_stall: req=%b addr=%h pc=%h ir=%h valid=%b required all 0",
                     mif.imem_req_out, mif.imem_addr_out, pc_out, ir_out, valid_out);
        end
        n_checks++;
        if (mif_w.imem_addr_out !== 32'hFFFF_FFF8 || valid_w !== 1'b0 || pc_w !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid_param: addr=%h valid=%b pc=%h required FFFFFFF8/0/0",
                     mif_w.imem_addr_out, valid_w, pc_w);
        end
        @(posedge clk); #1;
        stall_in = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail = 0;
        rst_n = 1'b0;
        stall_in = 1'b0;
        stall_w = 1'b0;
        redirect_in = 1'b0;
        redirect_pc_in = '0;
        mem_wait = 0;
        test_reset();
        test_zero_wait();
        test_wait2();
        test_stall_skid();
        test_redirect_outstanding();
        test_redirect_ack_stall();
        test_wrap();
        test_reset_mid_stall();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
